// File: rtl/sram_arb_pkg.sv
// Shared state and port-id types for the two-port SRAM arbiter.
// Latency: none (types only).
// Backpressure: none (types only).
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port that did not win last time wins.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own readiness.
module rr_pick2
  import sram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  port_id_t   last,
  output logic [1:0] grant
);

  // Tie goes to the port other than last; otherwise pass the single request through.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = (last == 1'b1) ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM port between the CPU path (port 0) and a secondary master (port 1), round-robin.
// Latency: accept at T, SRAM enabled T+1..T+WAIT_CYCLES, rvalid pulse at T+WAIT_CYCLES+1.
// Backpressure: reqN_ready only in IDLE; one transaction in flight. SRAM_ARBITER_STATS_EN adds grant counters.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_mem_ena,
  output logic              sram_wr_ena,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
`ifdef SRAM_ARBITER_STATS_EN
  output logic [15:0]       gnt0_count,
  output logic [15:0]       gnt1_count,
`endif
  output logic              busy
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("sram_arbiter: WAIT_CYCLES must be >= 1");
  end

  arb_state_t        state_q, state_d;
  port_id_t          owner_q, rr_last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [WAIT_W-1:0] wait_q;
  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic [1:0]        grant, ready, rvalid;
  logic              accept;

  // Reset asserts asynchronously and releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  rr_pick2 u_pick (
    .valid ({req1_valid, req0_valid}),
    .last  (rr_last_q),
    .grant (grant)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state plus handshake / SRAM strobes; SRAM is only enabled during ACCESS.
  always_comb begin
    state_d      = state_q;
    ready        = 2'b00;
    rvalid       = 2'b00;
    sram_mem_ena = 1'b0;
    sram_wr_ena  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_int_n) ready = grant;
        if (|ready) state_d = ACCESS;
      end
      ACCESS: begin
        sram_mem_ena = 1'b1;
        sram_wr_ena  = we_q;
        if (wait_q == '0) state_d = RESP;
      end
      RESP: begin
        rvalid[owner_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = |ready;

  // Request latches, wait counter and read capture on the last access cycle.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
    end else if (accept) begin
      owner_q   <= grant[1];
      rr_last_q <= grant[1];
      we_q      <= grant[1] ? req1_we    : req0_we;
      addr_q    <= grant[1] ? req1_addr  : req0_addr;
      wdata_q   <= grant[1] ? req1_wdata : req0_wdata;
      wait_q    <= WAIT_W'(WAIT_CYCLES - 1);
    end else if (state_q == ACCESS) begin
      if (wait_q == '0) rdata_q <= we_q ? '0 : sram_rdata;
      else              wait_q  <= wait_q - WAIT_W'(1);
    end
  end

  assign req0_ready  = ready[0];
  assign req1_ready  = ready[1];
  assign req0_rvalid = rvalid[0];
  assign req1_rvalid = rvalid[1];
  assign req0_rdata  = rvalid[0] ? rdata_q : '0;
  assign req1_rdata  = rvalid[1] ? rdata_q : '0;
  assign sram_addr   = addr_q;
  assign sram_wdata  = wdata_q;
  assign busy        = (state_q != IDLE);

`ifdef SRAM_ARBITER_STATS_EN
  // Per-port accept counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      gnt0_count <= '0;
      gnt1_count <= '0;
    end else begin
      if (ready[0]) gnt0_count <= gnt0_count + 16'd1;
      if (ready[1]) gnt1_count <= gnt1_count + 16'd1;
    end
  end
`endif

endmodule
